// File: rtl/deshift.sv
// Serial-in / parallel-out frame gatherer: packs DEPTH words of WIDTH bits into one frame.
// Optional feature: define DESHIFT_CHKSUM_EN to add o_chksum (XOR of the frame's words).
module deshift #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_busy,
    output logic [DEPTH*WIDTH-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic                   o_err
`ifdef DESHIFT_CHKSUM_EN
    ,
    output logic [WIDTH-1:0]       o_chksum
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = DEPTH * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] sreg_q, sreg_d;
    logic [FW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic [FW-1:0] sreg_shift;
    logic [CW-1:0] cnt_inc;

    assign sreg_shift = {sreg_q[FW-WIDTH-1:0], i_data};
    assign cnt_inc    = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_busy) begin
                    sreg_d  = sreg_shift;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (i_busy) begin
                    sreg_d = sreg_shift;
                    if (cnt_inc == LAST) begin
                        data_d  = sreg_shift;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // Short frame: partial words stay in sreg only, o_data untouched
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (i_busy) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (!i_busy) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q == RECV);

`ifdef DESHIFT_CHKSUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] chksum_q, chksum_d;

    // Accumulator restarts on the first word so a short frame never leaks into the next
    always_comb begin
        acc_d    = acc_q;
        chksum_d = chksum_q;
        if (i_busy) begin
            case (state_q)
                IDLE: acc_d = i_data;
                RECV: begin
                    acc_d = acc_q ^ i_data;
                    if (cnt_inc == LAST) begin
                        chksum_d = acc_q ^ i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            chksum_q <= '0;
        end else begin
            acc_q    <= acc_d;
            chksum_q <= chksum_d;
        end
    end

    assign o_chksum = chksum_q;
`endif

endmodule
